// File: rtl/snake_pkg.sv
// snake_pkg: shared cell types, playfield geometry and the cell-index helper
// used by the snake pixel generator and its cell RAM.
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int N_CELLS    = GRID_W * GRID_H;
  localparam int ADDR_W     = 11;

  localparam logic [9:0] PIX_NONE = 10'h3FF;

  // row*40 + col built from two shifts so no multiplier or divider is needed
  function automatic logic [ADDR_W-1:0] cell_index(input logic [4:0] row,
                                                   input logic [5:0] col);
    return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/snake_cell_ram.sv
// snake_cell_ram: 1200x2 simple dual-port cell store, one write port and one
// synchronous read port. No reset so it maps onto block RAM. A read of the
// address being written in the same cycle returns the previous contents.
module snake_cell_ram
  import snake_pkg::*;
#(
  parameter int DEPTH = N_CELLS,
  parameter int AW    = ADDR_W,
  parameter int DW    = 2
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [DW-1:0] i_wrData,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Write port; out-of-range addresses never touch the array
  always_ff @(posedge i_clk) begin
    if (i_we && (i_wrAddr < AW'(DEPTH))) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Registered read; out-of-range addresses read back as zero
  always_ff @(posedge i_clk) begin
    if (i_rdAddr < AW'(DEPTH)) begin
      r_q <= r_mem[i_rdAddr];
    end else begin
      r_q <= '0;
    end
  end

  assign o_rdData = r_q;

endmodule

// File: rtl/snake_pix_gen.sv
// snake_pix_gen: pixel source for the VGA timing controller. Maps a pixel
// coordinate to a 24-bit colour one cycle later from a 40x30 cell RAM, clears
// the RAM after reset or on request, blinks food and flashes game over.
// Optional feature macro: GRID_LINES_EN draws 1-pixel grid lines on cell edges.
module snake_pix_gen
  import snake_pkg::*;
#(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] COL_BG       = 24'h000000,
  parameter logic [23:0] COL_BODY     = 24'h00C000,
  parameter logic [23:0] COL_HEAD     = 24'h00FF80,
  parameter logic [23:0] COL_FOOD     = 24'hFF4000,
  parameter logic [23:0] COL_OVER     = 24'hFF0000
`ifdef GRID_LINES_EN
  ,
  parameter logic [23:0] COL_GRID     = 24'h202020
`endif
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  input  logic        cell_we,
  input  logic [10:0] cell_addr,
  input  logic [1:0]  cell_wdata,
  input  logic        clr_req,
  input  logic        game_over,
  output logic        clr_busy,
  output logic        frame_start
);

  clr_state_t  r_state;
  logic [10:0] r_clrAddr;
  logic        r_clrBusy;

  logic        r_frameStart;
  logic [5:0]  r_frameCnt;
  logic        r_blink;

  logic        r_pixInvalid;
  logic        r_pixBusy;
  logic        r_pixGameOver;
`ifdef GRID_LINES_EN
  logic        r_pixGrid;
`endif

  logic        w_we;
  logic [10:0] w_wrAddr;
  logic [1:0]  w_wrData;
  logic [10:0] w_rdAddr;
  logic [1:0]  w_ramQ;
  cell_t       w_cell;
  logic        w_pixInvalid;
  logic        w_frameEvent;
  logic [23:0] w_colour;

  // Clear FSM: sweeps every cell to EMPTY, restarts on clr_req, then idles in RUN
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
      r_clrBusy <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (clr_req) begin
            r_clrAddr <= '0;
          end else if (r_clrAddr == 11'(N_CELLS - 1)) begin
            r_clrAddr <= '0;
            r_state   <= ST_RUN;
            r_clrBusy <= 1'b0;
          end else begin
            r_clrAddr <= r_clrAddr + 11'd1;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            r_clrAddr <= '0;
            r_state   <= ST_CLEAR;
            r_clrBusy <= 1'b1;
          end
        end
        default: begin
          r_clrAddr <= '0;
          r_state   <= ST_CLEAR;
          r_clrBusy <= 1'b1;
        end
      endcase
    end
  end

  // Write port mux: the clear sweep owns the RAM, game writes only land in RUN
  always_comb begin
    w_we     = 1'b0;
    w_wrAddr = r_clrAddr;
    w_wrData = CELL_EMPTY;
    if (r_state == ST_CLEAR) begin
      w_we = 1'b1;
    end else begin
      w_we     = cell_we && (cell_addr < 11'(N_CELLS));
      w_wrAddr = cell_addr;
      w_wrData = cell_wdata;
    end
  end

  assign w_rdAddr     = cell_index(pix_y[8:CELL_SHIFT], pix_x[9:CELL_SHIFT]);
  assign w_pixInvalid = (pix_x == PIX_NONE) || (pix_y == PIX_NONE);
  assign w_frameEvent = (pix_x == 10'd0) && (pix_y == 10'd0);

  snake_cell_ram #(
    .DEPTH (N_CELLS),
    .AW    (ADDR_W),
    .DW    (2)
  ) u_cellRam (
    .i_clk    (vga_clk),
    .i_we     (w_we),
    .i_wrAddr (w_wrAddr),
    .i_wrData (w_wrData),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_ramQ)
  );

  // Frame pulse plus frame counter that flips the blink phase every BLINK_FRAMES frames
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_frameStart <= 1'b0;
      r_frameCnt   <= '0;
      r_blink      <= 1'b0;
    end else begin
      r_frameStart <= w_frameEvent;
      if (w_frameEvent) begin
        if (r_frameCnt == 6'(BLINK_FRAMES - 1)) begin
          r_frameCnt <= '0;
          r_blink    <= ~r_blink;
        end else begin
          r_frameCnt <= r_frameCnt + 6'd1;
        end
      end
    end
  end

  // Per-pixel flags registered alongside the RAM read so they line up with its data
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_pixInvalid  <= 1'b1;
      r_pixBusy     <= 1'b1;
      r_pixGameOver <= 1'b0;
`ifdef GRID_LINES_EN
      r_pixGrid     <= 1'b0;
`endif
    end else begin
      r_pixInvalid  <= w_pixInvalid;
      r_pixBusy     <= r_clrBusy;
      r_pixGameOver <= game_over;
`ifdef GRID_LINES_EN
      r_pixGrid     <= (pix_x[3:0] == 4'd0) || (pix_y[3:0] == 4'd0);
`endif
    end
  end

  assign w_cell = cell_t'(w_ramQ);

  // Colour decode: cell type, then grid, clear-in-progress and invalid overrides
  always_comb begin
    w_colour = COL_BG;
    case (w_cell)
      CELL_EMPTY: w_colour = COL_BG;
      CELL_BODY:  w_colour = (r_pixGameOver && r_blink) ? COL_OVER : COL_BODY;
      CELL_HEAD:  w_colour = (r_pixGameOver && r_blink) ? COL_OVER : COL_HEAD;
      CELL_FOOD:  w_colour = r_blink ? COL_BG : COL_FOOD;
      default:    w_colour = COL_BG;
    endcase
`ifdef GRID_LINES_EN
    if (r_pixGrid && (w_cell != CELL_HEAD)) begin
      w_colour = COL_GRID;
    end
`endif
    if (r_pixBusy) begin
      w_colour = COL_BG;
    end
    if (r_pixInvalid) begin
      w_colour = 24'h000000;
    end
  end

  assign pix_data    = w_colour;
  assign clr_busy    = r_clrBusy;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_snake_pix_gen.sv
// tb_snake_pix_gen: directed self-checking bench for snake_pix_gen.
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_snake_pix_gen;

  localparam int BLINK_FRAMES = 30;

  logic        vga_clk;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_data;
  logic        cell_we;
  logic [10:0] cell_addr;
  logic [1:0]  cell_wdata;
  logic        clr_req;
  logic        game_over;
  logic        clr_busy;
  logic        frame_start;

  int errors;
  int checks;

  int   mFrameCnt;
  logic mBlink;

  snake_pix_gen dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .cell_we     (cell_we),
    .cell_addr   (cell_addr),
    .cell_wdata  (cell_wdata),
    .clr_req     (clr_req),
    .game_over   (game_over),
    .clr_busy    (clr_busy),
    .frame_start (frame_start)
  );

  // 25 MHz pixel clock
  initial begin
    vga_clk = 1'b0;
    forever #20 vga_clk = ~vga_clk;
  end

  // Reference blink model: counts (0,0) pixels and flips phase every BLINK_FRAMES of them
  always @(posedge vga_clk) begin
    if (sys_rst) begin
      mFrameCnt <= 0;
      mBlink    <= 1'b0;
    end else if (pix_x == 10'd0 && pix_y == 10'd0) begin
      if (mFrameCnt == BLINK_FRAMES - 1) begin
        mFrameCnt <= 0;
        mBlink    <= ~mBlink;
      end else begin
        mFrameCnt <= mFrameCnt + 1;
      end
    end
  end

  task automatic present_pixel(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(negedge vga_clk);
  endtask

  task automatic write_cell(input logic [10:0] a, input logic [1:0] d);
    cell_we    = 1'b1;
    cell_addr  = a;
    cell_wdata = d;
    @(negedge vga_clk);
    cell_we    = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL reset_pix_data: got %h expected %h", pix_data, 24'h000000);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start);
    end
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_clr_busy: got %b expected 1", clr_busy);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_clear();
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    for (int c = 0; c < 1300; c++) begin
      if (clr_busy !== 1'b1) break;
      cnt++;
      present_pixel(10'((c * 7) % 640), 10'((c * 3) % 480));
      if (pix_data !== 24'h000000) begin
        if (bad == 0)
          $display("[TB] FAIL clear_pixel: cycle %0d got %h expected %h", c, pix_data, 24'h000000);
        bad++;
      end
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (cnt != 1200) begin
      errors++;
      $display("[TB] FAIL clear_cycles: got %0d expected %0d", cnt, 1200);
    end
  endtask

  task automatic test_head();
    write_cell(11'd41, 2'd2);
    write_cell(11'd42, 2'd1);
    write_cell(11'd1199, 2'd1);
    present_pixel(10'd16, 10'd16);
    checks++;
    if (pix_data !== 24'h00FF80) begin
      errors++;
      $display("[TB] FAIL head_16_16: got %h expected %h", pix_data, 24'h00FF80);
    end
    present_pixel(10'd15, 10'd16);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL left_of_head: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd31, 10'd31);
    checks++;
    if (pix_data !== 24'h00FF80) begin
      errors++;
      $display("[TB] FAIL head_corner: got %h expected %h", pix_data, 24'h00FF80);
    end
    present_pixel(10'd32, 10'd16);
    checks++;
    if (pix_data !== 24'h00C000) begin
      errors++;
      $display("[TB] FAIL body_42: got %h expected %h", pix_data, 24'h00C000);
    end
    present_pixel(10'd16, 10'd32);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL below_head: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd639, 10'd479);
    checks++;
    if (pix_data !== 24'h00C000) begin
      errors++;
      $display("[TB] FAIL last_cell: got %h expected %h", pix_data, 24'h00C000);
    end
    cell_we    = 1'b1;
    cell_addr  = 11'd100;
    cell_wdata = 2'd2;
    present_pixel(10'd320, 10'd32);
    cell_we    = 1'b0;
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL rdw_old: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd320, 10'd32);
    checks++;
    if (pix_data !== 24'h00FF80) begin
      errors++;
      $display("[TB] FAIL rdw_new: got %h expected %h", pix_data, 24'h00FF80);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic test_invalid();
    present_pixel(10'h3FF, 10'd16);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL invalid_x: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd16, 10'h3FF);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL invalid_y: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'h3FF, 10'h3FF);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL invalid_xy: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd16, 10'd16);
    checks++;
    if (pix_data !== 24'h00FF80) begin
      errors++;
      $display("[TB] FAIL valid_after_invalid: got %h expected %h", pix_data, 24'h00FF80);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic test_blink();
    logic [23:0] expCol;
    logic [23:0] prevCol;
    int toggles;
    toggles = 0;
    prevCol = '0;
    game_over = 1'b0;
    write_cell(11'd0, 2'd3);
    for (int f = 0; f <= 60; f++) begin
      present_pixel(10'd0, 10'd0);
      expCol = mBlink ? 24'h000000 : 24'hFF4000;
      checks++;
      if (frame_start !== 1'b1) begin
        errors++;
        $display("[TB] FAIL frame_start_pulse: frame %0d got %b expected 1", f, frame_start);
      end
      checks++;
      if (pix_data !== expCol) begin
        errors++;
        $display("[TB] FAIL food_origin: frame %0d got %h expected %h", f, pix_data, expCol);
      end
      present_pixel(10'd8, 10'd8);
      checks++;
      if (frame_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL frame_start_single: frame %0d got %b expected 0", f, frame_start);
      end
      checks++;
      if (pix_data !== expCol) begin
        errors++;
        $display("[TB] FAIL food_blink: frame %0d got %h expected %h", f, pix_data, expCol);
      end
      if (f > 0 && pix_data !== prevCol) toggles++;
      prevCol = pix_data;
    end
    checks++;
    if (toggles != 2) begin
      errors++;
      $display("[TB] FAIL food_toggles: got %0d expected %0d", toggles, 2);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic test_game_over();
    logic [23:0] expBody;
    logic [23:0] expHead;
    logic sawOn;
    logic sawOff;
    sawOn  = 1'b0;
    sawOff = 1'b0;
    write_cell(11'd5, 2'd1);
    game_over = 1'b1;
    for (int f = 0; f < 35; f++) begin
      present_pixel(10'd0, 10'd0);
      present_pixel(10'd88, 10'd8);
      expBody = mBlink ? 24'hFF0000 : 24'h00C000;
      expHead = mBlink ? 24'hFF0000 : 24'h00FF80;
      if (mBlink) sawOn = 1'b1;
      else sawOff = 1'b1;
      checks++;
      if (pix_data !== expBody) begin
        errors++;
        $display("[TB] FAIL over_body: frame %0d got %h expected %h", f, pix_data, expBody);
      end
      present_pixel(10'd20, 10'd20);
      checks++;
      if (pix_data !== expHead) begin
        errors++;
        $display("[TB] FAIL over_head: frame %0d got %h expected %h", f, pix_data, expHead);
      end
    end
    checks++;
    if (!(sawOn && sawOff)) begin
      errors++;
      $display("[TB] FAIL over_phases: got on=%b off=%b expected on=1 off=1", sawOn, sawOff);
    end
    game_over = 1'b0;
    write_cell(11'd1500, 2'd2);
    present_pixel(10'd320, 10'd112);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL oob_cell_300: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd576, 10'd176);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL oob_cell_476: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd88, 10'd8);
    checks++;
    if (pix_data !== 24'h00C000) begin
      errors++;
      $display("[TB] FAIL body_after_over: got %h expected %h", pix_data, 24'h00C000);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic test_clr_restart();
    int cnt;
    write_cell(11'd10, 2'd1);
    present_pixel(10'd168, 10'd8);
    checks++;
    if (pix_data !== 24'h00C000) begin
      errors++;
      $display("[TB] FAIL pre_clear_body: got %h expected %h", pix_data, 24'h00C000);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    clr_req = 1'b1;
    @(negedge vga_clk);
    clr_req = 1'b0;
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_req_busy: got %b expected 1", clr_busy);
    end
    repeat (600) @(negedge vga_clk);
    clr_req    = 1'b1;
    cell_we    = 1'b1;
    cell_addr  = 11'd8;
    cell_wdata = 2'd2;
    @(negedge vga_clk);
    clr_req = 1'b0;
    cell_we = 1'b0;
    cnt = 0;
    for (int c = 0; c < 1300; c++) begin
      if (clr_busy !== 1'b1) break;
      cnt++;
      if (cnt >= 1100) begin
        cell_we    = 1'b1;
        cell_addr  = 11'd3;
        cell_wdata = 2'd2;
      end
      @(negedge vga_clk);
    end
    cell_we = 1'b0;
    checks++;
    if (cnt != 1200) begin
      errors++;
      $display("[TB] FAIL restart_cycles: got %0d expected %0d", cnt, 1200);
    end
    present_pixel(10'd168, 10'd8);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL cleared_cell_10: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd56, 10'd8);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL dropped_we_cell_3: got %h expected %h", pix_data, 24'h000000);
    end
    present_pixel(10'd136, 10'd8);
    checks++;
    if (pix_data !== 24'h000000) begin
      errors++;
      $display("[TB] FAIL dropped_we_cell_8: got %h expected %h", pix_data, 24'h000000);
    end
    write_cell(11'd3, 2'd2);
    present_pixel(10'd56, 10'd8);
    checks++;
    if (pix_data !== 24'h00FF80) begin
      errors++;
      $display("[TB] FAIL write_after_clear: got %h expected %h", pix_data, 24'h00FF80);
    end
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  // Test sequence
  initial begin
    errors     = 0;
    checks     = 0;
    sys_rst    = 1'b1;
    pix_x      = 10'h3FF;
    pix_y      = 10'h3FF;
    cell_we    = 1'b0;
    cell_addr  = '0;
    cell_wdata = '0;
    clr_req    = 1'b0;
    game_over  = 1'b0;
    test_reset();
    test_clear();
    test_head();
    test_invalid();
    test_blink();
    test_game_over();
    test_clr_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
